ex_mem_stage: RTL and testbench

//  Parametrised EX->MEM pipeline register with valid/ready flow control. A 2-entry

---
 rtl/ex_mem_stage.sv | 124 ++++++++++++
 tb/tb_ex_mem_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: 2-entry skid buffer with valid/ready flow control,
// synchronous flush, and memory/writeback controls gated by out_valid.
module ex_mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_zero,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [DATA_WIDTH-1:0] in_read_register2,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_zero,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_read_register2,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_reg_write,
    output logic [REG_ADDR_W-1:0] out_write_reg,
    output logic [1:0]            occupancy
);

    localparam int unsigned EntW = 2 * DATA_WIDTH + REG_ADDR_W + 4;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e              state_q, state_d;
    logic [EntW-1:0]     head_q, head_d;
    logic [EntW-1:0]     skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic [EntW-1:0]     in_ent;
    logic                accept, drain;
    logic                head_mem_read, head_mem_write, head_reg_write;

    assign in_ent = {in_zero, in_result, in_read_register2,
                     in_mem_read, in_mem_write, in_reg_write, in_write_reg};

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash wins over everything; an in-flight accept is simply dropped.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_d  = in_ent;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        head_d = in_ent;
                    end else if (accept) begin
                        skid_d  = in_ent;
                        state_d = StFull;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (drain) begin
                        head_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign {out_zero, out_result, out_read_register2,
            head_mem_read, head_mem_write, head_reg_write, out_write_reg} = head_q;

    // Bubbles and squashed entries must never reach data memory or the register file.
    assign out_mem_read  = head_mem_read  & out_valid;
    assign out_mem_write = head_mem_write & out_valid;
    assign out_reg_write = head_reg_write & out_valid;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage at DATA_WIDTH=64, REG_ADDR_W=6: directed scenarios then random
// traffic, checked against a queue-based model of the stage.
module tb_ex_mem_stage;

    localparam int unsigned DW = 64;
    localparam int unsigned RW = 6;

    typedef struct {
        logic          zero;
        logic [DW-1:0] res;
        logic [DW-1:0] rs2;
        logic          mr;
        logic          mw;
        logic          rw;
        logic [RW-1:0] wr;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_zero = 1'b0;
    logic [DW-1:0] in_result = '0;
    logic [DW-1:0] in_read_register2 = '0;
    logic          in_mem_read = 1'b0;
    logic          in_mem_write = 1'b0;
    logic          in_reg_write = 1'b0;
    logic [RW-1:0] in_write_reg = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_zero;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_read_register2;
    logic          out_mem_read;
    logic          out_mem_write;
    logic          out_reg_write;
    logic [RW-1:0] out_write_reg;
    logic [1:0]    occupancy;

    ex_mem_stage #(
        .DATA_WIDTH(DW),
        .REG_ADDR_W(RW)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_zero           (in_zero),
        .in_result         (in_result),
        .in_read_register2 (in_read_register2),
        .in_mem_read       (in_mem_read),
        .in_mem_write      (in_mem_write),
        .in_reg_write      (in_reg_write),
        .in_write_reg      (in_write_reg),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_zero          (out_zero),
        .out_result        (out_result),
        .out_read_register2(out_read_register2),
        .out_mem_read      (out_mem_read),
        .out_mem_write     (out_mem_write),
        .out_reg_write     (out_reg_write),
        .out_write_reg     (out_write_reg),
        .occupancy         (occupancy)
    );

    always #5 clock = ~clock;

    int   n_chk  = 0;
    int   n_pass = 0;
    ent_t q[$];
    logic rdy_m = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        logic v;
        v = (q.size() != 0);
        chk({tag, " out_valid"}, out_valid, v);
        chk({tag, " in_ready"}, in_ready, rdy_m);
        chk({tag, " occupancy"}, occupancy, q.size());
        chk({tag, " mem_read"}, out_mem_read, v ? q[0].mr : 1'b0);
        chk({tag, " mem_write"}, out_mem_write, v ? q[0].mw : 1'b0);
        chk({tag, " reg_write"}, out_reg_write, v ? q[0].rw : 1'b0);
        if (v) begin
            chk({tag, " zero"}, out_zero, q[0].zero);
            chk({tag, " result"}, out_result, q[0].res);
            chk({tag, " rs2"}, out_read_register2, q[0].rs2);
            chk({tag, " write_reg"}, out_write_reg, q[0].wr);
        end
    endtask

    task automatic drive(input logic v, input ent_t e);
        in_valid          = v;
        in_zero           = e.zero;
        in_result         = e.res;
        in_read_register2 = e.rs2;
        in_mem_read       = e.mr;
        in_mem_write      = e.mw;
        in_reg_write      = e.rw;
        in_write_reg      = e.wr;
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.zero = 1'($urandom);
        e.res  = {$urandom, $urandom};
        e.rs2  = {$urandom, $urandom};
        e.mr   = 1'($urandom);
        e.mw   = 1'($urandom);
        e.rw   = 1'($urandom);
        e.wr   = RW'($urandom);
        return e;
    endfunction

    function automatic ent_t mk(input logic [DW-1:0] res, input logic mw);
        ent_t e;
        e.zero = 1'b0;
        e.res  = res;
        e.rs2  = ~res;
        e.mr   = 1'b0;
        e.mw   = mw;
        e.rw   = ~mw;
        e.wr   = res[RW-1:0];
        return e;
    endfunction

    // One clock: apply model rules at the edge, then compare at the falling edge.
    task automatic step(input string tag);
        ent_t cur;
        logic acc, drn;
        cur.zero = in_zero;
        cur.res  = in_result;
        cur.rs2  = in_read_register2;
        cur.mr   = in_mem_read;
        cur.mw   = in_mem_write;
        cur.rw   = in_reg_write;
        cur.wr   = in_write_reg;
        @(posedge clock);
        acc = in_valid && rdy_m;
        drn = (q.size() != 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(cur);
        end
        rdy_m = (q.size() < 2);
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        ent_t e;
        #12;
        chk("reset valid", out_valid, 1'b0);
        chk("reset ready", in_ready, 1'b1);
        chk("reset occ", occupancy, 2'd0);
        chk("reset result", out_result, '0);
        reset_n = 1'b1;
        @(negedge clock);

        // Streaming at full rate
        out_ready = 1'b1;
        drive(1'b1, mk(64'h10, 1'b0)); step("stream0");
        chk("stream0 res", out_result, 64'h10);
        drive(1'b1, mk(64'h20, 1'b0)); step("stream1");
        chk("stream1 res", out_result, 64'h20);
        drive(1'b1, mk(64'h30, 1'b0)); step("stream2");
        chk("stream2 res", out_result, 64'h30);
        chk("stream2 occ", occupancy, 2'd1);
        drive(1'b0, mk(64'h0, 1'b0)); step("stream_drain");

        // Backpressure fills the skid entry; C waits for in_ready
        out_ready = 1'b0;
        drive(1'b1, mk(64'hAAAA, 1'b0)); step("bp_a");
        drive(1'b1, mk(64'hBBBB, 1'b0)); step("bp_b");
        chk("bp full occ", occupancy, 2'd2);
        chk("bp full ready", in_ready, 1'b0);
        drive(1'b1, mk(64'hCCCC, 1'b0)); step("bp_c_blocked");
        chk("bp held", out_result, 64'hAAAA);
        out_ready = 1'b1;
        step("bp_drain_a");
        chk("bp head b", out_result, 64'hBBBB);
        step("bp_c_accept");
        chk("bp head c", out_result, 64'hCCCC);
        drive(1'b0, mk(64'h0, 1'b0)); step("bp_empty");

        // Flush while full with a store on the input
        out_ready = 1'b0;
        drive(1'b1, mk(64'h1111, 1'b1)); step("fl_a");
        drive(1'b1, mk(64'h2222, 1'b1)); step("fl_b");
        drive(1'b1, mk(64'h3333, 1'b1)); flush = 1'b1; step("flush");
        chk("flush valid", out_valid, 1'b0);
        chk("flush mw", out_mem_write, 1'b0);
        chk("flush occ", occupancy, 2'd0);
        chk("flush ready", in_ready, 1'b1);
        flush = 1'b0;
        drive(1'b0, mk(64'h3333, 1'b1)); step("post_flush");

        // Bubble carrying a stale store control
        step("bubble");
        chk("bubble mw", out_mem_write, 1'b0);

        // Async reset while full
        drive(1'b1, mk(64'h4444, 1'b1)); step("rs_a");
        drive(1'b1, mk(64'h5555, 1'b1)); step("rs_b");
        chk("rs full", occupancy, 2'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst valid", out_valid, 1'b0);
        chk("arst occ", occupancy, 2'd0);
        chk("arst ready", in_ready, 1'b1);
        chk("arst result", out_result, '0);
        chk("arst mw", out_mem_write, 1'b0);
        q.delete();
        rdy_m = 1'b1;
        #1 reset_n = 1'b1;
        @(negedge clock);
        out_ready = 1'b1;

        // Full-width fields pass through bit-exact
        e = mk(64'hDEADBEEF_CAFEF00D, 1'b0);
        e.wr = 6'd63;
        drive(1'b1, e); step("wide");
        chk("wide res", out_result, 64'hDEADBEEF_CAFEF00D);
        chk("wide wr", out_write_reg, 6'd63);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_ent());
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
